// File: rtl/washing_machine_plant_if.sv
// rtl/washing_machine_plant_if.sv - actuator/sensor bundle between washer controller and plant model
//
// Signals:
//   valve, heater, motor, pump, door_lock  actuator commands (controller -> plant)
//   full, hot, clean                       sensor levels (plant -> controller)
//   level                                  water level counter, CNT_W bits (debug)
//   fault, fault_code                      sticky illegal-command flag and first cause
// Modports:
//   master  controller side: drives actuators, reads sensors
//   slave   plant side: reads actuators, drives sensors
interface washing_machine_plant_if #(
   parameter int CNT_W = 8
);
   logic             valve;
   logic             heater;
   logic             motor;
   logic             pump;
   logic             door_lock;
   logic             full;
   logic             hot;
   logic             clean;
   logic [CNT_W-1:0] level;
   logic             fault;
   logic [1:0]       fault_code;

   modport master (
      output valve, heater, motor, pump, door_lock,
      input  full, hot, clean, level, fault, fault_code
   );

   modport slave (
      input  valve, heater, motor, pump, door_lock,
      output full, hot, clean, level, fault, fault_code
   );
endinterface

// File: rtl/washing_machine_plant.sv
// rtl/washing_machine_plant.sv - drum/water/heater/motor plant model with illegal-command fault capture
//
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-high reset, clears every register
//   s_bus   washing_machine_plant_if.slave: actuator commands in,
//           full/hot/clean/level/fault/fault_code out
// All outputs decode from registers only; there is no input-to-output path.
module washing_machine_plant #(
   parameter int CNT_W      = 8,
   parameter int FILL_TICKS = 20,
   parameter int HEAT_TICKS = 30,
   parameter int WASH_TICKS = 40,
   parameter int COOL_DIV   = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   washing_machine_plant_if.slave  s_bus
);
   localparam logic [CNT_W-1:0] L_FILL      = CNT_W'(FILL_TICKS);
   localparam logic [CNT_W-1:0] L_HEAT      = CNT_W'(HEAT_TICKS);
   localparam logic [CNT_W-1:0] L_WASH      = CNT_W'(WASH_TICKS);
   localparam logic [CNT_W-1:0] L_COOL_LAST = CNT_W'(COOL_DIV - 1);

   localparam logic [1:0] C_DOOR     = 2'd1;
   localparam logic [1:0] C_DRY_HEAT = 2'd2;
   localparam logic [1:0] C_OVERFLOW = 2'd3;

   logic [CNT_W-1:0] r_level;
   logic [CNT_W-1:0] r_temp;
   logic [CNT_W-1:0] r_wash;
   logic [CNT_W-1:0] r_cool_div;
   logic             r_fault;
   logic [1:0]       r_fault_code;

   logic [CNT_W-1:0] w_level_nxt;
   logic [CNT_W-1:0] w_temp_nxt;
   logic [CNT_W-1:0] w_wash_nxt;
   logic [CNT_W-1:0] w_cool_div_nxt;
   logic             w_fault_nxt;
   logic [1:0]       w_fault_code_nxt;

   logic             w_empty;
   logic             w_at_full;
   logic             w_door_err;
   logic             w_dry_err;
   logic             w_ovf_err;

   assign w_empty   = (r_level == '0);
   assign w_at_full = (r_level == L_FILL);

   assign w_door_err = (s_bus.valve | s_bus.heater | s_bus.motor) & ~s_bus.door_lock;
   assign w_dry_err  = s_bus.heater & w_empty;
   assign w_ovf_err  = s_bus.valve & ~s_bus.pump & w_at_full;

   // Water level: filling and draining at once cancel out.
   always_comb begin
      w_level_nxt = r_level;
      if (s_bus.valve && !s_bus.pump) begin
         if (r_level < L_FILL) w_level_nxt = r_level + 1'b1;
      end else if (s_bus.pump && !s_bus.valve) begin
         if (!w_empty) w_level_nxt = r_level - 1'b1;
      end
   end

   // Temperature: an empty drum has no water to hold heat, so it wins over
   // both heating and cooling. Cooling steps once every COOL_DIV heater-off cycles.
   always_comb begin
      w_temp_nxt     = r_temp;
      w_cool_div_nxt = r_cool_div;
      if (w_empty) begin
         w_temp_nxt     = '0;
         w_cool_div_nxt = '0;
      end else if (s_bus.heater) begin
         if (r_temp < L_HEAT) w_temp_nxt = r_temp + 1'b1;
         w_cool_div_nxt = '0;
      end else if (r_cool_div >= L_COOL_LAST) begin
         w_cool_div_nxt = '0;
         if (r_temp != '0) w_temp_nxt = r_temp - 1'b1;
      end else begin
         w_cool_div_nxt = r_cool_div + 1'b1;
      end
   end

   // Wash progress survives draining; only unlocking the door starts a new load.
   always_comb begin
      w_wash_nxt = r_wash;
      if (!s_bus.door_lock) begin
         w_wash_nxt = '0;
      end else if (s_bus.motor && w_at_full && (r_wash < L_WASH)) begin
         w_wash_nxt = r_wash + 1'b1;
      end
   end

   // First fault wins; later faults never overwrite the recorded cause.
   always_comb begin
      w_fault_nxt      = r_fault;
      w_fault_code_nxt = r_fault_code;
      if (!r_fault) begin
         if (w_door_err) begin
            w_fault_nxt      = 1'b1;
            w_fault_code_nxt = C_DOOR;
         end else if (w_dry_err) begin
            w_fault_nxt      = 1'b1;
            w_fault_code_nxt = C_DRY_HEAT;
         end else if (w_ovf_err) begin
            w_fault_nxt      = 1'b1;
            w_fault_code_nxt = C_OVERFLOW;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_level      <= '0;
         r_temp       <= '0;
         r_wash       <= '0;
         r_cool_div   <= '0;
         r_fault      <= 1'b0;
         r_fault_code <= 2'd0;
      end else begin
         r_level      <= w_level_nxt;
         r_temp       <= w_temp_nxt;
         r_wash       <= w_wash_nxt;
         r_cool_div   <= w_cool_div_nxt;
         r_fault      <= w_fault_nxt;
         r_fault_code <= w_fault_code_nxt;
      end
   end

   assign s_bus.full       = (r_level == L_FILL);
   assign s_bus.hot        = (r_temp == L_HEAT);
   assign s_bus.clean      = (r_wash == L_WASH);
   assign s_bus.level      = r_level;
   assign s_bus.fault      = r_fault;
   assign s_bus.fault_code = r_fault_code;
endmodule
